// File: rtl/uart_rx_buffer.sv
//------------------------------------------------------------------------------
// Module      : uart_rx_buffer
// Description : UART receive-side circular byte FIFO with frame-done detection,
//               occupancy flags and a sticky overrun flag.
//               Define UART_RX_BUF_FWFT_EN for first-word-fall-through read data;
//               otherwise rd_data is registered on each pop.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_buffer #(
    parameter int         DEPTH_LOG2 = 4,
    parameter logic [9:0] STOP_CNT   = 10'd9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_en,
    input  logic [9:0]            bit_cnt_in,
    input  logic [7:0]            rx_data_in,
    input  logic                  rd_en,
    input  logic                  clr_overrun,
    output logic [7:0]            rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overrun
);

    localparam int                  c_DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [7:0]            r_mem [c_DEPTH];
    logic [9:0]            r_cnt_q;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overrun;

    logic w_frame_done;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // Edge-detect on the counter so a dwell at STOP_CNT yields a single capture.
    assign w_frame_done = rx_en && (bit_cnt_in == STOP_CNT) && (r_cnt_q != STOP_CNT);
    assign w_pop        = rd_en && !empty;
    assign w_push       = w_frame_done && (!full || w_pop);
    assign w_drop       = w_frame_done && full && !w_pop;

    assign empty   = (r_count == '0);
    assign full    = (r_count == c_FULL);
    assign count   = r_count;
    assign overrun = r_overrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_q   <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_cnt_q <= bit_cnt_in;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A drop in the same cycle as a clear must stay visible to the host.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx_data_in;
        end
    end

`ifdef UART_RX_BUF_FWFT_EN
    assign rd_data = empty ? 8'h00 : r_mem[r_rd_ptr];
`else
    logic [7:0] r_rd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= 8'h00;
        end else if (w_pop) begin
            r_rd_data <= r_mem[r_rd_ptr];
        end
    end

    assign rd_data = r_rd_data;
`endif

endmodule

`default_nettype wire
